// File: rtl/aes_mux_pkg.sv
// Shared types and default sizes for the byte arbiter/mux.
package aes_mux_pkg;
  localparam int AES_BLOCK_BYTES = 16;
  localparam int BYTE_W          = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;
endpackage

// File: rtl/byte_arb_mux_rr_arbiter.sv
// Round-robin search: one-hot grant of the first requester above ptr (mod N_CH).
module rr_arbiter #(
  parameter int N_CH = 4,
  parameter int CW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] req,
  input  logic [CW-1:0]   ptr,
  output logic [N_CH-1:0] gnt
);
  logic          found;
  logic [CW-1:0] idx;

  // Walk ptr+1 .. ptr+N_CH so ptr itself has lowest priority.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = CW'((int'(ptr) + i) % N_CH);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/byte_arb_mux.sv
// Burst arbiter/mux: grants one byte channel for BURST beats, single output register.
module byte_arb_mux #(
  parameter int N_CH  = 4,
  parameter int WIDTH = aes_mux_pkg::BYTE_W,
  parameter int BURST = aes_mux_pkg::AES_BLOCK_BYTES,
  parameter int CW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [CW-1:0]         sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CW-1:0]         out_ch,
  output logic                  out_last,
  output logic                  busy
);
  import aes_mux_pkg::*;

  localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;

  state_t             state_q, state_d;
  logic [CW-1:0]      grant_q, grant_d;
  logic [CW-1:0]      last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [CW-1:0]      out_ch_q, out_ch_d;
  logic               out_last_q, out_last_d;
  logic               out_valid_q, out_valid_d;

  logic [N_CH-1:0]    rr_gnt;
  logic [CW-1:0]      rr_idx;
  logic               rr_any;
  logic               sel_hit;
  logic               slot_free;
  logic               in_xfer;
  logic               out_xfer;
  logic               burst_end;

  rr_arbiter #(.N_CH(N_CH), .CW(CW)) u_rr (
    .req (in_valid),
    .ptr (last_grant_q),
    .gnt (rr_gnt)
  );

  // One-hot round-robin grant to channel index.
  always_comb begin
    rr_idx = '0;
    for (int i = 0; i < N_CH; i++)
      if (rr_gnt[i]) rr_idx = CW'(i);
  end

  assign rr_any    = |rr_gnt;
  // sel beyond N_CH (non power-of-two channel counts) never grants.
  assign sel_hit   = ({1'b0, sel} < (CW+1)'(N_CH)) && in_valid[sel];
  assign slot_free = !out_valid_q || out_ready;
  assign in_xfer   = (state_q == aes_mux_pkg::BURST) && in_valid[grant_q] && slot_free;
  assign out_xfer  = out_valid_q && out_ready;
  assign burst_end = (cnt_q == CNT_W'(BURST - 1));

  // Only the granted channel sees ready, and only while the output slot can take a beat.
  always_comb begin
    in_ready = '0;
    if (state_q == aes_mux_pkg::BURST && slot_free) in_ready[grant_q] = 1'b1;
  end

  // Next-state: arbitration in IDLE, beat transfer and burst accounting in BURST.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q;
    if (out_xfer) out_valid_d = 1'b0;
    case (state_q)
      aes_mux_pkg::IDLE: begin
        if (!mode) begin
          if (sel_hit) begin
            grant_d = sel;
            cnt_d   = '0;
            state_d = aes_mux_pkg::BURST;
          end
        end else if (rr_any) begin
          grant_d = rr_idx;
          cnt_d   = '0;
          state_d = aes_mux_pkg::BURST;
        end
      end
      aes_mux_pkg::BURST: begin
        if (in_xfer) begin
          out_data_d  = in_data[grant_q*WIDTH +: WIDTH];
          out_ch_d    = grant_q;
          out_last_d  = burst_end;
          out_valid_d = 1'b1;
          cnt_d       = cnt_q + 1'b1;
          if (burst_end) begin
            cnt_d        = '0;
            last_grant_d = grant_q;
            state_d      = aes_mux_pkg::IDLE;
          end
        end
      end
      default: state_d = aes_mux_pkg::IDLE;
    endcase
  end

  // State register; last_grant resets to N_CH-1 so round-robin starts at channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= aes_mux_pkg::IDLE;
      grant_q      <= '0;
      last_grant_q <= CW'(N_CH - 1);
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == aes_mux_pkg::BURST);
endmodule

// File: tb/tb_byte_arb_mux.sv
// Scoreboard bench for byte_arb_mux: default 4x8/16 instance plus a 2-channel BURST=1 instance.
module tb_byte_arb_mux;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr;

  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_ready, out_last, busy;
  logic [1:0]  out_ch;

  logic        mode2;
  logic [0:0]  sel2;
  logic [15:0] in_data2;
  logic [1:0]  in_valid2, in_ready2;
  logic [7:0]  out_data2;
  logic        out_valid2, out_ready2, out_last2, busy2;
  logic [0:0]  out_ch2;

  byte_arb_mux dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_last(out_last), .busy(busy));

  byte_arb_mux #(.N_CH(2), .WIDTH(8), .BURST(1)) dut2 (
    .clk(clk), .rst(rst), .mode(mode2), .sel(sel2), .in_data(in_data2),
    .in_valid(in_valid2), .in_ready(in_ready2), .out_data(out_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_ch(out_ch2),
    .out_last(out_last2), .busy(busy2));

  // Each channel sources an incrementing byte, advanced on every accepted beat.
  logic [7:0] cnt [4];
  logic [7:0] cnt2 [2];
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (clr) cnt[k] <= 8'd0;
      else if (in_valid[k] && in_ready[k]) cnt[k] <= cnt[k] + 8'd1;
    for (int k = 0; k < 2; k++)
      if (clr) cnt2[k] <= 8'd0;
      else if (in_valid2[k] && in_ready2[k]) cnt2[k] <= cnt2[k] + 8'd1;
  end

  always_comb begin
    in_data  = '0;
    in_data2 = '0;
    for (int k = 0; k < 4; k++) in_data[k*8 +: 8] = cnt[k];
    for (int k = 0; k < 2; k++) in_data2[k*8 +: 8] = cnt2[k];
  end

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] ch;
    logic       last;
  } exp_t;

  exp_t sb[$];
  exp_t sb2[$];
  int checks = 0;
  int errors = 0;

  // Monitor: pops expected beats whenever an output transfer is about to happen.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      checks++;
      if (!$onehot0(in_ready)) begin
        errors++;
        $display("FAIL in_ready_onehot got=%b", in_ready);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected got d=%0h ch=%0d last=%0b", out_data, out_ch, out_last);
        end else begin
          e = sb.pop_front();
          if ({out_data, out_ch, out_last} !== e) begin
            errors++;
            $display("FAIL beat got d=%0h ch=%0d last=%0b exp d=%0h ch=%0d last=%0b",
                     out_data, out_ch, out_last, e.d, e.ch, e.last);
          end
        end
      end
      if (out_valid2 && out_ready2) begin
        checks++;
        if (sb2.size() == 0) begin
          errors++;
          $display("FAIL beat2_unexpected got d=%0h ch=%0d", out_data2, out_ch2);
        end else begin
          e = sb2.pop_front();
          if ({out_data2, 1'b0, out_ch2, out_last2} !== e) begin
            errors++;
            $display("FAIL beat2 got d=%0h ch=%0d last=%0b exp d=%0h ch=%0d last=%0b",
                     out_data2, out_ch2, out_last2, e.d, e.ch, e.last);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input int start, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d    = 8'(start + i);
      e.ch   = 2'(ch);
      e.last = ((start + i) % 16) == 15;
      sb.push_back(e);
    end
  endtask

  task automatic wait_cnt(input int ch, input int tgt);
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (int'(cnt[ch]) == tgt) return;
    end
    chk("wait_cnt_timeout", 32'(cnt[ch]), 32'(tgt));
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      tick();
      if (sb.size() == 0 && sb2.size() == 0 && !out_valid && !out_valid2) return;
    end
    chk("drain_timeout", 32'(sb.size() + sb2.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b1; in_valid = '0; in_valid2 = '0;
    tick(); tick();
    rst = 1'b0; clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, low, gaps, seen;
    exp_t e;
    rst = 1'b1; clr = 1'b1;
    mode = 1'b1; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
    mode2 = 1'b1; sel2 = 1'b0; in_valid2 = 2'b11; out_ready2 = 1'b1;
    tick(); tick();

    // Reset state, with requests pending to show they are ignored.
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data), 0);
    chk("rst_out_ch",    32'(out_ch), 0);
    chk("rst_out_last",  32'(out_last), 0);
    chk("rst_in_ready",  32'(in_ready), 0);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_in_ready2", 32'(in_ready2), 0);
    in_valid = '0; in_valid2 = '0;
    rst = 1'b0; clr = 1'b0;
    tick();

    // Explicit select, ch2 streams 0x00..0x0F; first output 2 cycles after valid.
    mode = 1'b0; sel = 2'd2;
    push(2, 0, 16);
    in_valid = 4'b0100;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); n++;
      if (out_valid) break;
    end
    chk("latency", 32'(n), 2);
    wait_cnt(2, 16);
    in_valid = '0;
    chk("idle_after_burst", 32'(busy), 0);
    drain();

    // Round-robin, all channels valid: 0,1,2,3,0 with one-cycle gaps.
    do_reset();
    mode = 1'b1;
    push(0, 0, 16); push(1, 0, 16); push(2, 0, 16); push(3, 0, 16); push(0, 16, 16);
    in_valid = 4'hF;
    low = 0; gaps = 0; seen = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (cnt[0] == 8'd32) begin
        in_valid = '0;
        break;
      end
      if (busy) begin
        if (seen != 0 && low != 0) begin
          gaps++;
          chk("rr_gap_len", 32'(low), 1);
        end
        seen = 1; low = 0;
      end else if (seen != 0) low++;
    end
    chk("rr_gap_count", 32'(gaps), 4);
    drain();

    // Backpressure: out_ready low 5 cycles mid-burst on ch1 (data continues from 16).
    mode = 1'b0; sel = 2'd1;
    push(1, 16, 16);
    in_valid = 4'b0010;
    wait_cnt(1, 21);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_data",  32'(out_data), 32'h14);
      chk("stall_ready", 32'(in_ready), 0);
      chk("stall_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    wait_cnt(1, 32);
    in_valid = '0;
    drain();

    // sel 2 -> 1 at beat 7: ch2 burst completes, then ch1.
    clr = 1'b1; tick(); clr = 1'b0;
    mode = 1'b0; sel = 2'd2;
    push(2, 0, 16); push(1, 0, 16);
    in_valid = 4'b0110;
    wait_cnt(2, 7);
    sel = 2'd1;
    wait_cnt(2, 16);
    wait_cnt(1, 16);
    in_valid = '0;
    chk("sel_ch2_count", 32'(cnt[2]), 16);
    drain();

    // Reset at beat 9 of a ch3 burst; beats 0..7 have left, beat 8 is discarded.
    clr = 1'b1; tick(); clr = 1'b0;
    mode = 1'b0; sel = 2'd3;
    push(3, 0, 8);
    in_valid = 4'b1000;
    wait_cnt(3, 9);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_busy",      32'(busy), 0);
    chk("midrst_in_ready",  32'(in_ready), 0);
    in_valid = '0; mode = 1'b1; clr = 1'b1;
    tick(); tick();
    chk("midrst_sb_empty", 32'(sb.size()), 0);
    rst = 1'b0; clr = 1'b0;
    push(0, 0, 16); push(2, 0, 16);
    in_valid = 4'b0101;
    wait_cnt(0, 16);
    wait_cnt(2, 16);
    in_valid = '0;
    drain();

    // BURST=1, two channels: alternating single beats, each last.
    for (int i = 0; i < 4; i++) begin
      e.d = 8'(i); e.ch = 2'd0; e.last = 1'b1; sb2.push_back(e);
      e.d = 8'(i); e.ch = 2'd1; e.last = 1'b1; sb2.push_back(e);
    end
    mode2 = 1'b1;
    in_valid2 = 2'b11;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (int'(cnt2[0]) + int'(cnt2[1]) == 8) break;
    end
    in_valid2 = '0;
    chk("b1_ch0_count", 32'(cnt2[0]), 4);
    chk("b1_ch1_count", 32'(cnt2[1]), 4);
    drain();

    chk("sb_final", 32'(sb.size() + sb2.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/byte_arb_mux.md
BYTE_ARB_MUX -- requirements
Module: byte_arb_mux

Interface
REQ-001 Parameter N_CH, default 4: number of byte input channels, 2..16.
REQ-002 Parameter WIDTH, default 8: data width per channel in bits.
REQ-003 Parameter BURST, default 16: beats per granted burst (one AES block), 1..256.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 mode  in  1  0 = explicit select, 1 = round-robin arbitration.
REQ-007 sel  in  CW = max(1, $clog2(N_CH))  channel requested when mode = 0.
REQ-008 in_data  in  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 in_valid  in  N_CH  per-channel valid.
REQ-010 in_ready  out  N_CH  per-channel ready; at most one bit high.
REQ-011 out_data  out  WIDTH  registered output byte.
REQ-012 out_valid  out  1  out_data is valid.
REQ-013 out_ready  in  1  downstream accepts out_data.
REQ-014 out_ch  out  CW  source channel of out_data.
REQ-015 out_last  out  1  out_data is the final beat of its burst.
REQ-016 busy  out  1  FSM is in state BURST.

Function
REQ-017 Transfers occur only when valid and ready are both high on the same edge, on both the input side and the output side.
REQ-018 FSM states: IDLE and BURST.
REQ-019 IDLE, mode = 0: if in_valid[sel] = 1 and sel < N_CH, latch grant = sel, clear the beat count, go to BURST; otherwise stay.
REQ-020 IDLE, mode = 1: grant the first channel with valid high, searching upward from last_grant+1 modulo N_CH; if none is valid, stay.
REQ-021 mode and sel are sampled only in IDLE; changes during BURST have no effect.
REQ-022 In IDLE all in_ready bits are 0, giving one bubble cycle per burst.
REQ-023 In BURST, in_ready[grant] = (!out_valid || out_ready); all other in_ready bits are 0.
REQ-024 Input transfer at edge t: out_data, out_ch and out_last are loaded and out_valid = 1 from t+1. Latency is 1 cycle.
REQ-025 Sustained rate in BURST is 1 beat per cycle while out_ready = 1.
REQ-026 out_valid clears after an output transfer with no simultaneous input transfer.
REQ-027 out_data, out_ch and out_last hold stable while out_valid = 1 and out_ready = 0.
REQ-028 The beat counter increments on each input transfer.
REQ-029 On the transfer with count = BURST-1: out_last is loaded as 1, last_grant is set to grant, and the FSM returns to IDLE.
REQ-030 BURST = 1: every beat carries out_last = 1.
REQ-031 Round-robin pointer wrap: last_grant = N_CH-1 searches from channel 0.
REQ-032 If in_valid[grant] drops mid-burst, the block waits in BURST; there is no timeout and no early termination.
REQ-033 An IDLE bubble cycle may overlap the final output beat still held in the register.

Reset
REQ-034 While rst = 1: state = IDLE, count = 0, last_grant = N_CH-1, grant = 0.
REQ-035 While rst = 1: out_valid = 0, out_last = 0, out_data = 0, out_ch = 0, in_ready = 0, busy = 0.
REQ-036 Reset mid-burst discards the partial burst and any held output beat; after release, arbitration starts fresh with channel 0 first in mode 1.

Structure
REQ-037 A shared package aes_mux_pkg holds the FSM state enum (IDLE, BURST) and the default constants: AES_BLOCK_BYTES = 16, BYTE_W = 8.
REQ-038 One sub-module, rr_arbiter (N_CH-wide, combinational, pointer input, one-hot grant output), is used for the mode 1 search.
REQ-039 The existing mux2_1/mux4_1 are not instantiated; the output data mux is an indexed part-select on grant.

Verification
REQ-040 mode = 0, sel = 2, ch2 streams 0x00..0x0F with out_ready = 1: 16 beats arrive on out_data, out_ch = 2, out_last only on 0x0F, and the first output appears 2 cycles after valid rises.
REQ-041 mode = 1, all 4 channels valid continuously: grant order is 0, 1, 2, 3, 0; each burst is 16 beats; busy = 0 for exactly 1 cycle between bursts.
REQ-042 out_ready = 0 for 5 cycles mid-burst: out_data holds, in_ready[grant] = 0, and no beat is lost or duplicated.
REQ-043 sel changed 2 -> 1 at beat 7: the burst completes on ch2, and the next burst comes from ch1.
REQ-044 rst asserted at beat 9: out_valid = 0 immediately; after release with mode = 1 and ch0 valid, grant = 0.
REQ-045 BURST = 1, N_CH = 2, both channels valid: beats alternate ch0/ch1, each with out_last = 1.
